// File: rtl/mem_access_if.sv
// Bus bundle for mem_access_unit: upstream LSU request/response plus the single-port memory bus.
// The master modport is the unit's view; slave is the LSU/memory side.
interface mem_access_if #(
  parameter int XLEN           = 64,
  parameter int MEM_ADDR_WIDTH = 16
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_wen;
  logic [2:0]                req_funct3;
  logic [XLEN-1:0]           req_addr;
  logic [XLEN-1:0]           req_wdata;
  logic                      resp_valid;
  logic [XLEN-1:0]           resp_rdata;
  logic                      resp_error;
  logic                      mem_ready;
  logic                      mem_valid;
  logic                      mem_wen;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [XLEN-1:0]           mem_wdata;
  logic [XLEN/8-1:0]         mem_wmask;
  logic                      mem_rvalid;
  logic [XLEN-1:0]           mem_rdata;

  modport master (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_ready, mem_rvalid, mem_rdata,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    output mem_ready, mem_rvalid, mem_rdata,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_access_unit.sv
// Converts byte-addressed B/H/W/D loads/stores into aligned word transactions with byte masks.
// Optional MEMUNIT_MISALIGN_EXC_EN: misaligned requests report resp_error instead of being aligned.
module mem_access_unit #(
  parameter int XLEN           = 64,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.master bus
);
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t                    state_r;
  logic                      mem_valid_r;
  logic                      mem_wen_r;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
  logic [XLEN-1:0]           mem_wdata_r;
  logic [NB-1:0]             mem_wmask_r;
  logic                      wen_r;
  logic [2:0]                funct3_r;
  logic [2:0]                off_r;

  logic [2:0]                size_mask_s;
  logic [2:0]                off_s;
  logic                      misalign_s;
  logic [NB-1:0]             wmask_s;
  logic [XLEN-1:0]           wdata_s;
  logic                      resp_valid_s;
  logic                      resp_error_s;
  logic [XLEN-1:0]           resp_rdata_s;
  logic                      unused_addr_s;

  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 3'd0;
      2'b01:   size_mask = 3'd1;
      2'b10:   size_mask = 3'd3;
      default: size_mask = 3'd7;
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [2:0] off);
    logic [NB-1:0] base;
    case (sz)
      2'b00:   base = NB'(8'h01);
      2'b01:   base = NB'(8'h03);
      2'b10:   base = NB'(8'h0F);
      default: base = NB'(8'hFF);
    endcase
    lane_mask = base << off;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [2:0] off,
                                                  input logic [2:0] funct3);
    logic [XLEN-1:0] x;
    x = rdata >> {off, 3'b000};
    case (funct3)
      3'b000:  load_extend = {{(XLEN-8){x[7]}}, x[7:0]};
      3'b001:  load_extend = {{(XLEN-16){x[15]}}, x[15:0]};
      3'b010:  load_extend = {{(XLEN-32){x[31]}}, x[31:0]};
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, x[7:0]};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, x[15:0]};
      3'b110:  load_extend = {{(XLEN-32){1'b0}}, x[31:0]};
      default: load_extend = x;
    endcase
  endfunction

  // Address bits above the memory window are ignored so accesses wrap.
  assign unused_addr_s = ^bus.req_addr[XLEN-1:MEM_ADDR_WIDTH+3];

  // Decode lane offset, byte mask and shifted store data of the incoming request.
  always_comb begin
    size_mask_s = size_mask(bus.req_funct3[1:0]);
`ifdef MEMUNIT_MISALIGN_EXC_EN
    misalign_s  = (bus.req_addr[2:0] & size_mask_s) != 3'd0;
    off_s       = bus.req_addr[2:0];
`else
    misalign_s  = 1'b0;
    off_s       = bus.req_addr[2:0] & ~size_mask_s;
`endif
    wmask_s     = bus.req_wen ? lane_mask(bus.req_funct3[1:0], off_s) : {NB{1'b0}};
    wdata_s     = bus.req_wdata << {off_s, 3'b000};
  end

  // Control FSM and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      mem_valid_r <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= {MEM_ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
      mem_wmask_r <= {NB{1'b0}};
      wen_r       <= 1'b0;
      funct3_r    <= 3'd0;
      off_r       <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            wen_r    <= bus.req_wen;
            funct3_r <= bus.req_funct3;
            off_r    <= off_s;
            if (misalign_s) begin
              state_r <= ERR;
            end else begin
              state_r     <= ISSUE;
              mem_valid_r <= 1'b1;
              mem_wen_r   <= bus.req_wen;
              mem_addr_r  <= bus.req_addr[MEM_ADDR_WIDTH+2:3];
              mem_wdata_r <= wdata_s;
              mem_wmask_r <= wmask_s;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            state_r     <= WAIT;
            mem_valid_r <= 1'b0;
            mem_wen_r   <= 1'b0;
            mem_wmask_r <= {NB{1'b0}};
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state_r <= IDLE;
          end
        end
        ERR: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Completion: memory rvalid only counts while waiting; the error pulse comes from ERR.
  always_comb begin
    resp_valid_s = 1'b0;
    resp_error_s = 1'b0;
    resp_rdata_s = {XLEN{1'b0}};
    case (state_r)
      WAIT: begin
        if (bus.mem_rvalid) begin
          resp_valid_s = 1'b1;
          resp_rdata_s = wen_r ? {XLEN{1'b0}} : load_extend(bus.mem_rdata, off_r, funct3_r);
        end else begin
          resp_valid_s = 1'b0;
        end
      end
      ERR: begin
        resp_valid_s = 1'b1;
`ifdef MEMUNIT_MISALIGN_EXC_EN
        resp_error_s = 1'b1;
`else
        resp_error_s = 1'b0;
`endif
      end
      default: begin
        resp_valid_s = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_rdata = resp_rdata_s;
  assign bus.resp_error = resp_error_s;
  assign bus.mem_valid  = mem_valid_r;
  assign bus.mem_wen    = mem_wen_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_wmask  = mem_wmask_r;
endmodule
